addr_mapper: RTL and testbench
==============================

ADDR_MAPPER -- requirements
Module: addr_mapper

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  NUM_PERIPH  4        number of one-hot peripheral selects (1..8)
  PAGE_W      5        page-register width; physical space = 2^(PAGE_W+14) bytes
  ROM_TOP     16'h2000 first logical address above the ROM overlay
  MEM_WAIT    0        wait cycles inserted on RAM accesses (0..15)
  ROM_WAIT    1        wait cycles inserted on ROM accesses (0..15)
  IO_WAIT     1        wait cycles inserted on IO accesses (0..15)
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  clk_i        in   1              single clock; all state on rising edge
  rst_i        in   1              reset, synchronous, active-high
  addr_i       in   16             CPU address bus
  data_i       in   8              CPU write data
  wr_n         in   1              CPU write strobe, active-low
  mreq_n       in   1              memory request, active-low
  ioreq_n      in   1              IO request, active-low
  data_o       out  8              register readback data
  phys_addr_o  out  PAGE_W+14      translated physical address
  rom_cs       out  1              ROM select
  ram_cs       out  1              RAM select
  periph_cs    out  NUM_PERIPH     one-hot peripheral select
  addr_dec_cs  out  1              this block's registers selected
  wait_n       out  1              CPU wait request, active-low

Function
REQ-003 Registers: page[0..3] (PAGE_W bits) at IO ports 0xF8..0xFB; ctrl at 0xFE (bit0 = rom_disable); io_bank (8 bits) at 0xFF.
REQ-004 Register write SHALL commit exactly once per bus cycle: on the first clock with wr_n=0, ioreq_n=0, mreq_n=1 after a clock where (wr_n|ioreq_n)=1; held strobes SHALL NOT rewrite.
REQ-005 Writes to ports other than REQ-003 SHALL change no state; page writes SHALL keep data_i[PAGE_W-1:0] only.
REQ-006 phys_addr_o SHALL be combinational {page[addr_i[15:14]], addr_i[13:0]}.
REQ-007 mreq_n=0: rom_cs=1 if addr_i<ROM_TOP and rom_disable=0, else ram_cs=1; exactly one asserted.
REQ-008 ioreq_n=0, mreq_n=1, addr_i[7:0] in {F8..FB,FE,FF}: addr_dec_cs=1, periph_cs=0.
REQ-009 ioreq_n=0, mreq_n=1, other port: periph_cs[io_bank]=1 if io_bank<NUM_PERIPH, else periph_cs all zero.
REQ-010 mreq_n and ioreq_n both low: memory decode only; no IO select, no register write.
REQ-011 data_o SHALL be combinational, zero-extended register value when addr_dec_cs=1, else 8'h00.
REQ-012 Wait FSM states IDLE, WAIT, HOLD; request = (mreq_n=0 or ioreq_n=0).
REQ-013 IDLE + request: load counter with ROM_WAIT/MEM_WAIT/IO_WAIT per REQ-007..010 class; go WAIT if >0, else HOLD.
REQ-014 WAIT: wait_n=0 combinationally from the first request cycle; decrement each clock; at count 1 go HOLD; total wait_n=0 cycles = loaded value.
REQ-015 HOLD: wait_n=1 until request deasserts, then IDLE; request removed during WAIT SHALL return to IDLE with wait_n=1.
REQ-016 Register values SHALL NOT depend on the FSM; page change mid-access takes effect combinationally.

Reset
REQ-017 rst_i=1 at a clock edge: page[i]=i, rom_disable=0, io_bank=0, FSM=IDLE, counter=0, write-edge tracker=idle; wait_n=1 while rst_i=1.
REQ-018 Reset mid-WAIT SHALL abort the wait; the next request after release restarts from IDLE.

Verification
REQ-019 After reset, read 0xF8..0xFB, 0xFE, 0xFF -> data_o = 00,01,02,03,00,00; mreq at 0x1FFF -> rom_cs=1; 0x2000 -> ram_cs=1.
REQ-020 Write 0x1F to 0xF9, mreq at 0x4123 -> phys_addr_o=0x7C123 (PAGE_W=5); write 0x01 to 0xFE, mreq at 0x0000 -> ram_cs=1.
REQ-021 io_bank=2, IO at 0x10 -> periph_cs=4'b0100; io_bank=7 -> periph_cs=0; IO at 0xFE -> addr_dec_cs=1.
REQ-022 ROM_WAIT=3, mreq at 0x0100 held 6 cycles -> wait_n low exactly 3 cycles then high; MEM_WAIT=0 access -> wait_n never low.
REQ-023 wr_n/ioreq_n held low 4 cycles to 0xFF with data_i changing each cycle -> io_bank = first-cycle data only.
REQ-024 rst_i pulsed during WAIT -> wait_n=1 next cycle, all registers at REQ-017 values.

Source files
------------

// File: rtl/addr_mapper.sv
// Banked address translator for an 8-bit CPU: four 16 KiB logical windows map onto a paged
// physical space, with ROM overlay, IO peripheral steering and a per-class wait-state generator.
module addr_mapper #(
    parameter int          NUM_PERIPH = 4,
    parameter int          PAGE_W     = 5,
    parameter logic [15:0] ROM_TOP    = 16'h2000,
    parameter int          MEM_WAIT   = 0,
    parameter int          ROM_WAIT   = 1,
    parameter int          IO_WAIT    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           addr_i,
    input  logic [7:0]            data_i,
    input  logic                  wr_n,
    input  logic                  mreq_n,
    input  logic                  ioreq_n,
    output logic [7:0]            data_o,
    output logic [PAGE_W+13:0]    phys_addr_o,
    output logic                  rom_cs,
    output logic                  ram_cs,
    output logic [NUM_PERIPH-1:0] periph_cs,
    output logic                  addr_dec_cs,
    output logic                  wait_n
);

    localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
    localparam logic [3:0] MEM_W = 4'(MEM_WAIT);
    localparam logic [3:0] IO_W  = 4'(IO_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    logic [PAGE_W-1:0] page [4];
    logic              rom_disable;
    logic [7:0]        io_bank;
    state_t            state;
    logic [3:0]        wait_cnt;
    logic              strobe_idle;

    logic [7:0] port;
    logic       mem_req;
    logic       io_only;
    logic       request;
    logic       is_page_port;
    logic       is_ctrl_port;
    logic       is_bank_port;
    logic       reg_port;
    logic       rom_hit;
    logic       write_fire;
    logic [3:0] wait_load;

    assign port         = addr_i[7:0];
    assign mem_req      = !mreq_n;
    // A simultaneous memory request wins: IO decode and register writes only on pure IO cycles.
    assign io_only      = !ioreq_n && mreq_n;
    assign request      = !mreq_n || !ioreq_n;
    assign is_page_port = (port[7:2] == 6'b111110);
    assign is_ctrl_port = (port == 8'hFE);
    assign is_bank_port = (port == 8'hFF);
    assign reg_port     = is_page_port || is_ctrl_port || is_bank_port;
    assign rom_hit      = (addr_i < ROM_TOP) && !rom_disable;

    assign rom_cs       = mem_req && rom_hit;
    assign ram_cs       = mem_req && !rom_hit;
    assign addr_dec_cs  = io_only && reg_port;
    assign phys_addr_o  = {page[addr_i[15:14]], addr_i[13:0]};

    // strobe_idle remembers that the previous clock had no IO write strobe, so a held strobe commits once.
    assign write_fire   = !wr_n && !ioreq_n && mreq_n && strobe_idle;

    always_comb begin
        periph_cs = '0;
        if (io_only && !reg_port) begin
            for (int i = 0; i < NUM_PERIPH; i++) begin
                if (io_bank == 8'(i)) begin
                    periph_cs[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        data_o = 8'h00;
        if (addr_dec_cs) begin
            if (is_page_port) begin
                data_o[PAGE_W-1:0] = page[port[1:0]];
            end else if (is_ctrl_port) begin
                data_o[0] = rom_disable;
            end else begin
                data_o = io_bank;
            end
        end
    end

    always_comb begin
        wait_load = IO_W;
        if (mem_req) begin
            wait_load = rom_hit ? ROM_W : MEM_W;
        end
    end

    // The first wait cycle is driven from IDLE so the CPU sees wait_n low on its first request clock.
    always_comb begin
        wait_n = 1'b1;
        if (!rst_i) begin
            case (state)
                S_IDLE:  if (request && (wait_load != 4'd0)) wait_n = 1'b0;
                S_WAIT:  if (request && (wait_cnt > 4'd1))   wait_n = 1'b0;
                default: wait_n = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                page[i] <= PAGE_W'(i);
            end
            rom_disable <= 1'b0;
            io_bank     <= 8'h00;
            strobe_idle <= 1'b1;
        end else begin
            strobe_idle <= wr_n || ioreq_n;
            if (write_fire) begin
                if (is_page_port) begin
                    page[port[1:0]] <= data_i[PAGE_W-1:0];
                end else if (is_ctrl_port) begin
                    rom_disable <= data_i[0];
                end else if (is_bank_port) begin
                    io_bank <= data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (request) begin
                        wait_cnt <= wait_load;
                        state    <= (wait_load != 4'd0) ? S_WAIT : S_HOLD;
                    end
                end
                S_WAIT: begin
                    if (!request) begin
                        state    <= S_IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt <= 4'd1) begin
                        state    <= S_HOLD;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (!request) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_mapper.sv
// Randomised bench for addr_mapper: register file, decode and wait states are checked against
// an arithmetic model of the register contents and per-class wait lengths.
module tb_addr_mapper;

    localparam int NP       = 4;
    localparam int PW       = 5;
    localparam int ROM_TOPV = 'h2000;
    localparam int ROM_WV   = 3;
    localparam int MEM_WV   = 0;
    localparam int IO_WV    = 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [15:0]   addr_i = 16'h0000;
    logic [7:0]    data_i = 8'h00;
    logic          wr_n = 1'b1;
    logic          mreq_n = 1'b1;
    logic          ioreq_n = 1'b1;
    logic [7:0]    data_o;
    logic [PW+13:0] phys_addr_o;
    logic          rom_cs;
    logic          ram_cs;
    logic [NP-1:0] periph_cs;
    logic          addr_dec_cs;
    logic          wait_n;

    int checks = 0;
    int passed = 0;

    int m_page [4];
    int m_rom_dis;
    int m_io_bank;

    addr_mapper #(
        .NUM_PERIPH(NP), .PAGE_W(PW), .ROM_TOP(16'h2000),
        .MEM_WAIT(MEM_WV), .ROM_WAIT(ROM_WV), .IO_WAIT(IO_WV)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i), .wr_n(wr_n),
        .mreq_n(mreq_n), .ioreq_n(ioreq_n), .data_o(data_o), .phys_addr_o(phys_addr_o),
        .rom_cs(rom_cs), .ram_cs(ram_cs), .periph_cs(periph_cs),
        .addr_dec_cs(addr_dec_cs), .wait_n(wait_n)
    );

    always #5 clk_i = ~clk_i;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_page[i] = i;
        m_rom_dis = 0;
        m_io_bank = 0;
    endfunction

    function automatic bit is_reg(input int p);
        return (p >= 'hF8 && p <= 'hFB) || p == 'hFE || p == 'hFF;
    endfunction

    function automatic int model_reg(input int p);
        if (p >= 'hF8 && p <= 'hFB) return m_page[p - 'hF8];
        if (p == 'hFE) return m_rom_dis;
        return m_io_bank;
    endfunction

    function automatic logic [7:0] pick_port();
        logic [7:0] regs [6] = '{8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFE, 8'hFF};
        if ($urandom_range(0, 1) == 1) return regs[$urandom_range(0, 5)];
        return 8'($urandom);
    endfunction

    task automatic go_idle();
        @(negedge clk_i);
        mreq_n = 1'b1; ioreq_n = 1'b1; wr_n = 1'b1;
    endtask

    // One IO write bus cycle holding the strobe for 'cycles' clocks; scramble changes data each clock.
    task automatic io_write(input logic [7:0] p, input logic [7:0] d, input int cycles, input bit scramble);
        @(negedge clk_i);
        addr_i = {8'($urandom), p}; data_i = d; wr_n = 1'b0; ioreq_n = 1'b0; mreq_n = 1'b1;
        for (int i = 1; i < cycles; i++) begin
            @(negedge clk_i);
            if (scramble) data_i = d ^ 8'($urandom_range(1, 255));
        end
        go_idle();
        if (p >= 8'hF8 && p <= 8'hFB) m_page[int'(p) - 'hF8] = int'(d) % (1 << PW);
        else if (p == 8'hFE) m_rom_dis = int'(d) % 2;
        else if (p == 8'hFF) m_io_bank = int'(d);
    endtask

    task automatic check_io_read(input logic [7:0] p);
        logic       exp_dec;
        logic [7:0] exp_data;
        logic [3:0] exp_per;
        @(negedge clk_i);
        addr_i = {8'($urandom), p}; wr_n = 1'b1; ioreq_n = 1'b0; mreq_n = 1'b1;
        #1;
        exp_dec  = is_reg(int'(p));
        exp_data = exp_dec ? 8'(model_reg(int'(p))) : 8'h00;
        exp_per  = (!exp_dec && m_io_bank < NP) ? 4'(1 << m_io_bank) : 4'h0;
        checks++;
        if (addr_dec_cs !== exp_dec) $display("FAIL io_dec port %h: got %b expected %b", p, addr_dec_cs, exp_dec);
        else passed++;
        checks++;
        if (data_o !== exp_data) $display("FAIL io_data port %h: got %h expected %h", p, data_o, exp_data);
        else passed++;
        checks++;
        if (periph_cs !== exp_per) $display("FAIL periph port %h bank %0d: got %b expected %b", p, m_io_bank, periph_cs, exp_per);
        else passed++;
        go_idle();
    endtask

    // Memory access; with both_low the IO strobe and a write are also asserted and must be ignored.
    task automatic check_mem(input logic [15:0] a, input bit both_low);
        logic        exp_rom;
        logic [18:0] exp_phys;
        @(negedge clk_i);
        addr_i = a; mreq_n = 1'b0; ioreq_n = !both_low; wr_n = !both_low; data_i = 8'($urandom);
        #1;
        exp_rom  = (int'(a) < ROM_TOPV) && (m_rom_dis == 0);
        exp_phys = 19'(m_page[int'(a) / 16384] * 16384 + int'(a) % 16384);
        checks++;
        if (rom_cs !== exp_rom || ram_cs !== !exp_rom)
            $display("FAIL mem_sel addr %h: got rom=%b ram=%b expected rom=%b", a, rom_cs, ram_cs, exp_rom);
        else passed++;
        checks++;
        if (phys_addr_o !== exp_phys) $display("FAIL phys addr %h: got %h expected %h", a, phys_addr_o, exp_phys);
        else passed++;
        checks++;
        if (periph_cs !== 4'h0 || addr_dec_cs !== 1'b0 || data_o !== 8'h00)
            $display("FAIL mem_no_io addr %h: got periph=%b dec=%b data=%h expected 0", a, periph_cs, addr_dec_cs, data_o);
        else passed++;
        go_idle();
    endtask

    // Holds a request for 'hold' clocks and counts the clocks with wait_n low.
    task automatic check_wait(input logic [15:0] a, input bit is_mem, input int hold, input int exp_low);
        int   low = 0;
        logic last = 1'b0;
        @(negedge clk_i);
        addr_i = a; wr_n = 1'b1; mreq_n = !is_mem; ioreq_n = is_mem;
        for (int i = 0; i < hold; i++) begin
            #1;
            if (wait_n === 1'b0) low++;
            last = wait_n;
            @(negedge clk_i);
        end
        mreq_n = 1'b1; ioreq_n = 1'b1;
        checks++;
        if (low != exp_low || last !== 1'b1)
            $display("FAIL wait_len addr %h: got %0d low cycles end=%b expected %0d end=1", a, low, last, exp_low);
        else passed++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        addr_i = 16'h0100; mreq_n = 1'b0;
        #1;
        checks++;
        if (wait_n !== 1'b1) $display("FAIL wait_in_reset: got %b expected 1", wait_n);
        else passed++;
        @(negedge clk_i);
        rst_i = 1'b0; mreq_n = 1'b1;
        model_reset();
        foreach (m_page[i]) check_io_read(8'(8'hF8 + i));
        check_io_read(8'hFE);
        check_io_read(8'hFF);
        check_mem(16'h1FFF, 1'b0);
        check_mem(16'h2000, 1'b0);
    endtask

    task automatic test_paging();
        io_write(8'hF9, 8'h1F, 1, 1'b0);
        @(negedge clk_i);
        addr_i = 16'h4123; mreq_n = 1'b0;
        #1;
        checks++;
        if (phys_addr_o !== 19'h7C123) $display("FAIL page_f9: got %h expected 7c123", phys_addr_o);
        else passed++;
        go_idle();
        io_write(8'hFE, 8'h01, 1, 1'b0);
        check_mem(16'h0000, 1'b0);
        io_write(8'hFB, 8'hE6, 2, 1'b0);
        check_mem(16'hC555, 1'b0);
        io_write(8'hFE, 8'h00, 1, 1'b0);
        check_mem(16'h0000, 1'b0);
    endtask

    task automatic test_io_decode();
        io_write(8'hFF, 8'h02, 1, 1'b0);
        @(negedge clk_i);
        addr_i = 16'h0010; ioreq_n = 1'b0;
        #1;
        checks++;
        if (periph_cs !== 4'b0100) $display("FAIL periph_bank2: got %b expected 0100", periph_cs);
        else passed++;
        go_idle();
        io_write(8'hFF, 8'h07, 1, 1'b0);
        check_io_read(8'h10);
        check_io_read(8'hFE);
        io_write(8'hFF, 8'h03, 1, 1'b0);
        check_io_read(8'h42);
        io_write(8'h37, 8'h55, 1, 1'b0);
        check_io_read(8'hFF);
    endtask

    task automatic test_held_write();
        io_write(8'hFF, 8'h5A, 4, 1'b1);
        check_io_read(8'hFF);
        io_write(8'hFA, 8'h0C, 3, 1'b1);
        check_io_read(8'hFA);
    endtask

    task automatic test_wait_states();
        io_write(8'hFE, 8'h00, 1, 1'b0);
        check_wait(16'h0100, 1'b1, 6, ROM_WV);
        check_wait(16'h8000, 1'b1, 4, MEM_WV);
        check_wait(16'h0010, 1'b0, 4, IO_WV);
        @(negedge clk_i);
        addr_i = 16'h0100; mreq_n = 1'b0;
        @(negedge clk_i);
        mreq_n = 1'b1;
        #1;
        checks++;
        if (wait_n !== 1'b1) $display("FAIL wait_abort: got %b expected 1", wait_n);
        else passed++;
        check_wait(16'h0100, 1'b1, 6, ROM_WV);
    endtask

    task automatic test_reset_mid_wait();
        io_write(8'hF8, 8'h11, 1, 1'b0);
        io_write(8'hFE, 8'h01, 1, 1'b0);
        io_write(8'hFF, 8'h03, 1, 1'b0);
        io_write(8'hFE, 8'h00, 1, 1'b0);
        @(negedge clk_i);
        addr_i = 16'h0200; mreq_n = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++;
        if (wait_n !== 1'b1) $display("FAIL reset_wait_abort: got %b expected 1", wait_n);
        else passed++;
        @(negedge clk_i);
        rst_i = 1'b0; mreq_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (wait_n !== 1'b1) $display("FAIL wait_after_reset: got %b expected 1", wait_n);
        else passed++;
        foreach (m_page[i]) check_io_read(8'(8'hF8 + i));
        check_io_read(8'hFE);
        check_io_read(8'hFF);
        check_wait(16'h0200, 1'b1, 6, ROM_WV);
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  p;
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'h1FFF)) : 16'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    p = pick_port();
                    io_write(p, (p == 8'hFF && $urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom),
                             $urandom_range(1, 3), 1'($urandom_range(0, 1)));
                end
                1: check_mem(a, 1'b0);
                2: check_io_read(pick_port());
                default: check_mem({a[15:8], 8'hF8 + 8'($urandom_range(0, 3))}, 1'b1);
            endcase
        end
        foreach (m_page[i]) check_io_read(8'(8'hF8 + i));
        check_io_read(8'hFE);
        check_io_read(8'hFF);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_paging();
        test_io_decode();
        test_held_write();
        test_wait_states();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
